// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared state type, mode decode and idle-word constant for
//            spi_slave_param.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } spi_state_e;

   localparam logic [31:0] TX_IDLE_DEFAULT = 32'hFFFF_FFFF;

   // mosi is sampled on the sclk rising edge when CPOL and CPHA agree.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Purpose  : Synchronises sclk, cs_n and mosi into the system clock domain
//            and detects rising/falling edges of the synchronised sclk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2,
   parameter bit SCLK_IDLE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic cs_n_s,
   output logic mosi_s,
   output logic sclk_rise,
   output logic sclk_fall
);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_last_q, sclk_last_d;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_last_d = sclk_sync_q[SYNC_STAGES-1];
   end

   // sclk resets to its idle level so no false edge appears after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_last_q <= SCLK_IDLE;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_last_q <= sclk_last_d;
      end
   end

   assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_sync_q[SYNC_STAGES-1] & ~sclk_last_q;
   assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] &  sclk_last_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Purpose  : Oversampled SPI slave, all four modes, DATA_W-bit words, many
//            words per frame. Define SPI_SLAVE_ECHO_EN to echo the last rx
//            word instead of TX_IDLE when no tx word is available.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param
   import spi_pkg::*;
#(
   parameter int                 DATA_W      = 8,
   parameter bit                 CPOL        = 1'b0,
   parameter bit                 CPHA        = 1'b0,
   parameter bit                 MSB_FIRST   = 1'b1,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0]  TX_IDLE     = TX_IDLE_DEFAULT[DATA_W-1:0]
) (
   input  logic              clock_in,
   input  logic              rs_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              rx_overrun,
   output logic              tx_underrun,
   input  logic              flag_clr
);

   localparam int               CNT_W       = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   logic cs_n_s, mosi_s, sclk_rise, sclk_fall;
   logic sample_edge, shift_edge, load;

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [DATA_W-1:0] tx_word;
   logic              rx_valid_q, rx_valid_d;
   logic              miso_q, miso_d;
   logic              ovr_q, ovr_d;
   logic              und_q, und_d;
`ifdef SPI_SLAVE_ECHO_EN
   logic [DATA_W-1:0] echo_q, echo_d;
`endif

   spi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .SCLK_IDLE   (CPOL)
   ) u_pin_sync (
      .clk       (clock_in),
      .rst_n     (rs_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .cs_n_s    (cs_n_s),
      .mosi_s    (mosi_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall)
   );

   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

   function automatic logic first_bit(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
      return MSB_FIRST ? {v[DATA_W-2:0], 1'b1} : {1'b1, v[DATA_W-1:1]};
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
      return MSB_FIRST ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
   endfunction

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      miso_d     = miso_q;
      ovr_d      = ovr_q;
      und_d      = und_q;
      tx_word    = TX_IDLE;
      tx_ready   = 1'b0;
      load       = 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
      echo_d     = echo_q;
`endif

      if (flag_clr) begin
         ovr_d = 1'b0;
         und_d = 1'b0;
      end
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!cs_n_s) begin
               state_d   = XFER;
               bit_cnt_d = '0;
               load      = 1'b1;
            end
         end
         XFER: begin
            if (cs_n_s) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               miso_d    = 1'b1;
            end else if (bit_cnt_q == CNT_LAST) begin
               bit_cnt_d = '0;
               load      = 1'b1;
`ifdef SPI_SLAVE_ECHO_EN
               echo_d    = rx_shift_q;
`endif
               if (!rx_valid_q || rx_ready) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  ovr_d = 1'b1;
               end
            end else if (sample_edge) begin
               rx_shift_d = shift_in(rx_shift_q, mosi_s);
               bit_cnt_d  = bit_cnt_q + CNT_ONE;
            end else if (shift_edge && (CPHA || (bit_cnt_q != '0))) begin
               // CPHA=0 drove bit 0 at load, so the edge before the first sample is skipped
               miso_d     = first_bit(tx_shift_q);
               tx_shift_d = shift_out(tx_shift_q);
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (tx_valid) begin
            tx_word  = tx_data;
            tx_ready = 1'b1;
         end else begin
`ifdef SPI_SLAVE_ECHO_EN
            tx_word  = echo_d;
`else
            tx_word  = TX_IDLE;
`endif
            und_d    = 1'b1;
         end
         if (CPHA) begin
            tx_shift_d = tx_word;
         end else begin
            miso_d     = first_bit(tx_word);
            tx_shift_d = shift_out(tx_word);
         end
      end
   end

   always_ff @(posedge clock_in or negedge rs_n) begin
      if (!rs_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         miso_q     <= 1'b1;
         ovr_q      <= 1'b0;
         und_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         miso_q     <= miso_d;
         ovr_q      <= ovr_d;
         und_q      <= und_d;
      end
   end

`ifdef SPI_SLAVE_ECHO_EN
   always_ff @(posedge clock_in or negedge rs_n) begin
      if (!rs_n) begin
         echo_q <= '0;
      end else begin
         echo_q <= echo_d;
      end
   end
`endif

   assign miso        = miso_q;
   assign miso_oe     = (state_q == XFER);
   assign busy        = (state_q == XFER);
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_overrun  = ovr_q;
   assign tx_underrun = und_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Purpose  : Directed self-checking bench: one 8-bit mode-0 MSB-first slave
//            plus four 16-bit LSB-first slaves, one per SPI mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

   localparam int HALF = 8;
   localparam int SYNC = 2;
`ifdef SPI_SLAVE_ECHO_EN
   localparam logic [31:0] EXP_IDLE = 32'h3C;
`else
   localparam logic [31:0] EXP_IDLE = 32'hFF;
`endif

   logic       clk = 1'b0;
   logic       rs_n;
   logic [4:0] sclk_v, cs_v, mosi_v;
   wire  [4:0] miso_v, oe_v, busy_v;

   logic [7:0] tx_data0;
   logic       tx_valid0, rx_ready0, flag_clr0;
   wire        tx_ready0, rx_valid0, ovr0, und0;
   wire  [7:0] rx_data0;

   wire  [3:0] txr16, rxv16, ovr16, und16;
   wire  [15:0] rx16 [4];

   int n_cmp = 0;
   int n_err = 0;
   int txr_cnt = 0;
   int lat;
   logic [31:0] got;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_ready0) txr_cnt <= txr_cnt + 1;
   end

   spi_slave_param #(
      .DATA_W (8), .CPOL (1'b0), .CPHA (1'b0), .MSB_FIRST (1'b1), .SYNC_STAGES (SYNC)
   ) u_dut (
      .clock_in (clk), .rs_n (rs_n), .sclk (sclk_v[0]), .cs_n (cs_v[0]), .mosi (mosi_v[0]),
      .miso (miso_v[0]), .miso_oe (oe_v[0]), .tx_data (tx_data0), .tx_valid (tx_valid0),
      .tx_ready (tx_ready0), .rx_data (rx_data0), .rx_valid (rx_valid0), .rx_ready (rx_ready0),
      .busy (busy_v[0]), .rx_overrun (ovr0), .tx_underrun (und0), .flag_clr (flag_clr0)
   );

   for (genvar i = 0; i < 4; i++) begin : g_modes
      spi_slave_param #(
         .DATA_W (16), .CPOL ((i >> 1) == 1), .CPHA ((i & 1) == 1),
         .MSB_FIRST (1'b0), .SYNC_STAGES (SYNC)
      ) u_mode (
         .clock_in (clk), .rs_n (rs_n), .sclk (sclk_v[i+1]), .cs_n (cs_v[i+1]),
         .mosi (mosi_v[i+1]), .miso (miso_v[i+1]), .miso_oe (oe_v[i+1]),
         .tx_data (16'hC3A5), .tx_valid (1'b1), .tx_ready (txr16[i]),
         .rx_data (rx16[i]), .rx_valid (rxv16[i]), .rx_ready (1'b1),
         .busy (busy_v[i+1]), .rx_overrun (ovr16[i]), .tx_underrun (und16[i]),
         .flag_clr (1'b0)
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic half_wait();
      repeat (HALF) @(negedge clk);
   endtask

   function automatic int mode_of(input int m);
      return (m == 0) ? 0 : m - 1;
   endfunction

   task automatic frame_start(input int m);
      sclk_v[m] = (mode_of(m) >= 2);
      cs_v[m]   = 1'b0;
      for (int k = 0; k < HALF; k++) begin
         @(negedge clk);
         if (m == 0 && tx_ready0) begin
            @(posedge clk);
            #1 tx_valid0 = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic frame_end(input int m);
      half_wait();
      cs_v[m] = 1'b1;
      half_wait();
   endtask

   task automatic xfer_word(input int m, input int nbits, input logic [31:0] w,
                            input bit msb, input bit meas, output logic [31:0] rd);
      logic cpol, cpha;
      int   idx;
      cpol = (mode_of(m) >= 2);
      cpha = (mode_of(m) % 2) == 1;
      rd   = '0;
      for (int b = 0; b < nbits; b++) begin
         idx = msb ? nbits - 1 - b : b;
         if (!cpha) begin
            mosi_v[m] = w[idx];
            half_wait();
            rd[idx]   = miso_v[m];
            sclk_v[m] = ~cpol;
            if (meas && b == nbits - 1) begin
               lat = 0;
               for (int k = 1; k <= HALF; k++) begin
                  @(negedge clk);
                  if (lat == 0 && rx_valid0) lat = k;
               end
            end else begin
               half_wait();
            end
            sclk_v[m] = cpol;
         end else begin
            half_wait();
            sclk_v[m] = ~cpol;
            mosi_v[m] = w[idx];
            half_wait();
            rd[idx]   = miso_v[m];
            sclk_v[m] = cpol;
         end
      end
   endtask

   task automatic drain_rx();
      rx_ready0 = 1'b1;
      @(negedge clk);
      rx_ready0 = 1'b0;
      @(negedge clk);
      check_eq("rx_valid_drop", rx_valid0, 1'b0);
   endtask

   task automatic clear_flags();
      flag_clr0 = 1'b1;
      @(negedge clk);
      flag_clr0 = 1'b0;
      @(negedge clk);
      check_eq("flags_cleared", {ovr0, und0}, 2'b00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rs_n = 1'b0;
      sclk_v = 5'b11000;
      cs_v = 5'b11111;
      mosi_v = 5'b00000;
      tx_data0 = 8'h00; tx_valid0 = 1'b0; rx_ready0 = 1'b0; flag_clr0 = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_ctl", {miso_v[0], oe_v[0], tx_ready0, rx_valid0, busy_v[0], ovr0, und0}, 7'b1000000);
      check_eq("reset_rx_data", rx_data0, 8'h00);
      rs_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0, 8 bit: tx 0xA9 preloaded, master sends 0x3C
      tx_data0 = 8'hA9; tx_valid0 = 1'b1;
      base = txr_cnt;
      frame_start(0);
      check_eq("selected", {busy_v[0], oe_v[0]}, 2'b11);
      xfer_word(0, 8, 32'h3C, 1'b1, 1'b1, got);
      frame_end(0);
      check_eq("m0_miso_word", got, 32'hA9);
      check_eq("m0_rx_data", rx_data0, 8'h3C);
      check_eq("m0_rx_valid", rx_valid0, 1'b1);
      check_eq("m0_latency", lat, SYNC + 2);
      check_eq("m0_tx_ready_pulses", txr_cnt - base, 1);
      check_eq("deselected", {busy_v[0], oe_v[0], miso_v[0]}, 3'b001);
      drain_rx();
      clear_flags();

      // Underrun: no tx word at frame start
      frame_start(0);
      xfer_word(0, 8, 32'h5A, 1'b1, 1'b0, got);
      frame_end(0);
      check_eq("ur_miso_word", got, EXP_IDLE);
      check_eq("ur_flag", und0, 1'b1);
      check_eq("ur_rx_data", rx_data0, 8'h5A);
      drain_rx();
      clear_flags();

      // Three words, rx_ready low
      frame_start(0);
      xfer_word(0, 8, 32'h11, 1'b1, 1'b0, got);
      check_eq("ov_w1_data", rx_data0, 8'h11);
      check_eq("ov_w1_flag", ovr0, 1'b0);
      xfer_word(0, 8, 32'h22, 1'b1, 1'b0, got);
      check_eq("ov_w2_flag", ovr0, 1'b1);
      xfer_word(0, 8, 32'h33, 1'b1, 1'b0, got);
      frame_end(0);
      check_eq("ov_w3_data", rx_data0, 8'h11);
      check_eq("ov_valid_held", rx_valid0, 1'b1);
      clear_flags();
      drain_rx();

      // Abort after 5 bits
      frame_start(0);
      xfer_word(0, 5, 32'h1F, 1'b1, 1'b0, got);
      cs_v[0] = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (lat == 0 && !busy_v[0] && !oe_v[0]) lat = k;
      end
      check_eq("abort_release", (lat >= 1) && (lat <= SYNC + 1), 1'b1);
      check_eq("abort_no_rx", {rx_valid0, ovr0}, 2'b00);
      frame_start(0);
      xfer_word(0, 8, 32'h96, 1'b1, 1'b0, got);
      frame_end(0);
      check_eq("abort_next_rx", rx_data0, 8'h96);
      check_eq("abort_next_valid", rx_valid0, 1'b1);
      drain_rx();

      // Asynchronous reset in the middle of a word
      tx_data0 = 8'h77; tx_valid0 = 1'b1;
      frame_start(0);
      xfer_word(0, 3, 32'h5, 1'b1, 1'b0, got);
      @(posedge clk);
      #3 rs_n = 1'b0;
      #1;
      check_eq("rst_mid_ctl", {miso_v[0], oe_v[0], tx_ready0, rx_valid0, busy_v[0], ovr0, und0}, 7'b1000000);
      check_eq("rst_mid_rx_data", rx_data0, 8'h00);
      cs_v[0] = 1'b1;
      sclk_v[0] = 1'b0;
      tx_valid0 = 1'b0;
      repeat (3) @(negedge clk);
      rs_n = 1'b1;
      repeat (2) @(negedge clk);
      tx_data0 = 8'hE4; tx_valid0 = 1'b1;
      frame_start(0);
      xfer_word(0, 8, 32'hC5, 1'b1, 1'b0, got);
      frame_end(0);
      check_eq("rst_next_miso", got, 32'hE4);
      check_eq("rst_next_rx", rx_data0, 8'hC5);

      // All four modes, 16 bit, LSB first
      for (int m = 1; m <= 4; m++) begin
         frame_start(m);
         xfer_word(m, 16, 32'h1234, 1'b0, 1'b0, got);
         frame_end(m);
         check_eq($sformatf("mode%0d_rx", m - 1), rx16[m-1], 16'h1234);
         check_eq($sformatf("mode%0d_miso", m - 1), got, 32'hC3A5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
